// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: sequences one SRAM access per load/store,
// stalls the front of the pipe while it runs, and registers the result to WB.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [5:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_result,
    input  logic [4:0]  ex_wreg,
    input  logic        ex_wen,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [5:0]  mem_op,
    input  logic [31:0] mem_rdata,
    output logic        stall_req,
    output logic        wb_valid,
    output logic [31:0] wb_wdata,
    output logic [4:0]  wb_wreg,
    output logic        wb_wen,
    output logic        addr_err
);

    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SW = 6'b101011;

    localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q;

    logic [5:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  wreg_q;
    logic        wen_q;

    logic is_load, is_store, is_mem, is_word;
    logic in_window, aligned, mem_legal;
    logic accept_mem, reject_mem, accept_alu;
    logic last_beat, latched_store;

    // Request decode; the SRAM window is 0x8000_0000..0x807F_FFFF (top 9 bits fixed).
    assign is_load   = (ex_op == OP_LB) || (ex_op == OP_LW);
    assign is_store  = (ex_op == OP_SB) || (ex_op == OP_SW);
    assign is_mem    = is_load || is_store;
    assign is_word   = (ex_op == OP_LW) || (ex_op == OP_SW);
    assign in_window = (ex_addr[31:23] == 9'h100);
    assign aligned   = !is_word || (ex_addr[1:0] == 2'b00);
    assign mem_legal = is_mem && in_window && aligned;

    assign accept_mem = (state_q == ST_IDLE) && ex_valid && mem_legal;
    assign reject_mem = (state_q == ST_IDLE) && ex_valid && is_mem && !mem_legal;
    assign accept_alu = (state_q == ST_IDLE) && ex_valid && !is_mem;

    assign last_beat     = (state_q == ST_ACCESS) && (cnt_q == 3'd0);
    assign latched_store = (op_q == OP_SB) || (op_q == OP_SW);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_mem) begin
                    state_d   = ST_ACCESS;
                    stall_req = 1'b1;
                end
            end
            ST_ACCESS: begin
                stall_req = 1'b1;
                mem_ce    = 1'b1;
                mem_we    = latched_store;
                if (cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else if (accept_mem) begin
            cnt_q <= CNT_LOAD;
        end else if ((state_q == ST_ACCESS) && (cnt_q != 3'd0)) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    // Request capture; only updated on accept, so the SRAM-side bus holds
    // its last value outside ACCESS and ignores EX while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wreg_q  <= '0;
            wen_q   <= 1'b0;
        end else if (accept_mem) begin
            op_q    <= ex_op;
            addr_q  <= ex_addr;
            wdata_q <= ex_wdata;
            wreg_q  <= ex_wreg;
            wen_q   <= ex_wen;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_op    = op_q;

    // Writeback register: pulses for one cycle after an ALU op, a rejected
    // access, or the final ACCESS beat (which lands the pulse in DONE).
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_wdata <= '0;
            wb_wreg  <= '0;
            wb_wen   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
            addr_err <= 1'b0;
            if (accept_alu) begin
                wb_valid <= 1'b1;
                wb_wdata <= ex_result;
                wb_wreg  <= ex_wreg;
                wb_wen   <= ex_wen;
            end else if (reject_mem) begin
                wb_valid <= 1'b1;
                wb_wreg  <= ex_wreg;
                addr_err <= 1'b1;
            end else if (last_beat) begin
                wb_valid <= 1'b1;
                wb_wreg  <= wreg_q;
                wb_wen   <= wen_q && !latched_store;
                if (!latched_store) begin
                    wb_wdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (WAIT_CYCLES = 2): ALU pass-through,
// loads, stores, address rejection, reset abort and back-to-back loads.
module tb_mem_access_ctrl;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_ALU = 6'b001111;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [5:0]  ex_op;
    logic [31:0] ex_addr, ex_wdata, ex_result;
    logic [4:0]  ex_wreg;
    logic        ex_wen;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [5:0]  mem_op;
    logic [31:0] mem_rdata;
    logic        stall_req, wb_valid, wb_wen, addr_err;
    logic [31:0] wb_wdata;
    logic [4:0]  wb_wreg;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_ctrl #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_result(ex_result),
        .ex_wreg(ex_wreg), .ex_wen(ex_wen),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_op(mem_op), .mem_rdata(mem_rdata),
        .stall_req(stall_req),
        .wb_valid(wb_valid), .wb_wdata(wb_wdata), .wb_wreg(wb_wreg),
        .wb_wen(wb_wen), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] res,
                         input logic [4:0] wreg, input logic wen);
        ex_valid  = v;
        ex_op     = op;
        ex_addr   = addr;
        ex_wdata  = wd;
        ex_result = res;
        ex_wreg   = wreg;
        ex_wen    = wen;
        #1;
    endtask

    logic [5:0]  leg_op   [6];
    logic [31:0] leg_addr [6];
    logic        leg_exp  [6];

    initial begin
        rst       = 1'b1;
        mem_rdata = '0;
        drive(1'b0, 6'd0, '0, '0, '0, 5'd0, 1'b0);
        tick();
        tick();
        check("rst_mem_ce",    mem_ce,    0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_wb_valid",  wb_valid,  0);
        check("rst_addr_err",  addr_err,  0);
        check("rst_stall",     stall_req, 0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_wb_wdata",  wb_wdata,  0);
        rst = 1'b0;

        // Legality decode seen through stall_req, never clocked in.
        leg_op[0] = OP_LB;  leg_addr[0] = 32'h807F_FFFF; leg_exp[0] = 1'b1;
        leg_op[1] = OP_LW;  leg_addr[1] = 32'h807F_FFFC; leg_exp[1] = 1'b1;
        leg_op[2] = OP_LW;  leg_addr[2] = 32'h8080_0000; leg_exp[2] = 1'b0;
        leg_op[3] = OP_SB;  leg_addr[3] = 32'h7FFF_FFFF; leg_exp[3] = 1'b0;
        leg_op[4] = OP_SW;  leg_addr[4] = 32'h8000_0001; leg_exp[4] = 1'b0;
        leg_op[5] = OP_ALU; leg_addr[5] = 32'h8000_0000; leg_exp[5] = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, leg_op[i], leg_addr[i], '0, '0, 5'd1, 1'b1);
            check($sformatf("legal_stall_%0d", i), stall_req, leg_exp[i]);
        end
        drive(1'b0, 6'd0, '0, '0, '0, 5'd0, 1'b0);

        // ALU op passes straight through.
        tick();
        drive(1'b1, OP_ALU, 32'h0, 32'h0, 32'h1234_0000, 5'd3, 1'b1);
        check("alu_stall_T", stall_req, 0);
        tick();
        drive(1'b0, 6'd0, '0, '0, '0, 5'd0, 1'b0);
        check("alu_wb_valid", wb_valid, 1);
        check("alu_wb_wdata", wb_wdata, 32'h1234_0000);
        check("alu_wb_wreg",  wb_wreg,  3);
        check("alu_wb_wen",   wb_wen,   1);
        check("alu_stall",    stall_req, 0);
        check("alu_mem_ce",   mem_ce,   0);
        tick();
        check("alu_wb_drop",  wb_valid, 0);

        // LW 0x80000010.
        drive(1'b1, OP_LW, 32'h8000_0010, 32'h0, 32'h0, 5'd5, 1'b1);
        check("lw_stall_T",  stall_req, 1);
        check("lw_ce_T",     mem_ce,    0);
        tick();
        drive(1'b0, 6'd0, '0, '0, '0, 5'd0, 1'b0);
        mem_rdata = 32'hDEAD_BEEF;
        check("lw_ce_T1",    mem_ce,    1);
        check("lw_we_T1",    mem_we,    0);
        check("lw_addr_T1",  mem_addr,  32'h8000_0010);
        check("lw_op_T1",    mem_op,    OP_LW);
        check("lw_stall_T1", stall_req, 1);
        check("lw_wbv_T1",   wb_valid,  0);
        tick();
        check("lw_ce_T2",    mem_ce,    1);
        check("lw_stall_T2", stall_req, 1);
        check("lw_wbv_T2",   wb_valid,  0);
        tick();
        mem_rdata = 32'h0;
        check("lw_ce_T3",    mem_ce,    0);
        check("lw_stall_T3", stall_req, 0);
        check("lw_wbv_T3",   wb_valid,  1);
        check("lw_wdata_T3", wb_wdata,  32'hDEAD_BEEF);
        check("lw_wreg_T3",  wb_wreg,   5);
        check("lw_wen_T3",   wb_wen,    1);
        tick();
        check("lw_wbv_T4",   wb_valid,  0);
        check("lw_addr_hold", mem_addr, 32'h8000_0010);

        // SB 0x80400003 with EX changing underneath while busy.
        drive(1'b1, OP_SB, 32'h8040_0003, 32'h0000_00AB, 32'h0, 5'd7, 1'b1);
        check("sb_stall_T", stall_req, 1);
        tick();
        drive(1'b1, OP_LW, 32'h8000_0100, 32'h5555_5555, 32'h0, 5'd8, 1'b1);
        check("sb_ce_T1",    mem_ce,    1);
        check("sb_we_T1",    mem_we,    1);
        check("sb_addr_T1",  mem_addr,  32'h8040_0003);
        check("sb_wdata_T1", mem_wdata, 32'h0000_00AB);
        check("sb_op_T1",    mem_op,    OP_SB);
        tick();
        check("sb_ce_T2",    mem_ce,    1);
        check("sb_we_T2",    mem_we,    1);
        check("sb_addr_T2",  mem_addr,  32'h8040_0003);
        check("sb_op_T2",    mem_op,    OP_SB);
        tick();
        check("sb_stall_done", stall_req, 0);
        drive(1'b0, 6'd0, '0, '0, '0, 5'd0, 1'b0);
        check("sb_ce_T3",    mem_ce,    0);
        check("sb_we_T3",    mem_we,    0);
        check("sb_wbv_T3",   wb_valid,  1);
        check("sb_wen_T3",   wb_wen,    0);
        tick();
        check("sb_wbv_T4",   wb_valid,  0);

        // Rejected accesses: misaligned LW, out-of-window SW.
        drive(1'b1, OP_LW, 32'h8000_0002, 32'h0, 32'h0, 5'd4, 1'b1);
        check("badlw_stall", stall_req, 0);
        tick();
        drive(1'b0, 6'd0, '0, '0, '0, 5'd0, 1'b0);
        check("badlw_err",   addr_err,  1);
        check("badlw_wbv",   wb_valid,  1);
        check("badlw_wen",   wb_wen,    0);
        check("badlw_ce",    mem_ce,    0);
        tick();
        check("badlw_err_drop", addr_err, 0);
        check("badlw_ce2",   mem_ce,    0);
        drive(1'b1, OP_SW, 32'h9000_0000, 32'h1, 32'h0, 5'd4, 1'b1);
        check("badsw_stall", stall_req, 0);
        tick();
        drive(1'b0, 6'd0, '0, '0, '0, 5'd0, 1'b0);
        check("badsw_err",   addr_err,  1);
        check("badsw_wen",   wb_wen,    0);
        check("badsw_ce",    mem_ce,    0);
        tick();
        check("badsw_err_drop", addr_err, 0);
        check("badsw_wbv_drop", wb_valid, 0);

        // Reset during the first ACCESS cycle of an SW.
        drive(1'b1, OP_SW, 32'h8000_0020, 32'hCAFE_F00D, 32'h0, 5'd6, 1'b1);
        tick();
        drive(1'b0, 6'd0, '0, '0, '0, 5'd0, 1'b0);
        check("rsw_ce_T1", mem_ce, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rsw_ce_after",    mem_ce,    0);
        check("rsw_stall_after", stall_req, 0);
        check("rsw_wbv_after",   wb_valid,  0);
        tick();
        check("rsw_ce_next",  mem_ce,   0);
        check("rsw_wbv_next", wb_valid, 0);
        drive(1'b1, OP_LW, 32'h8000_0040, 32'h0, 32'h0, 5'd9, 1'b1);
        check("rlw_stall_T", stall_req, 1);
        tick();
        drive(1'b0, 6'd0, '0, '0, '0, 5'd0, 1'b0);
        mem_rdata = 32'h0BAD_F00D;
        check("rlw_ce_T1",   mem_ce,   1);
        check("rlw_addr_T1", mem_addr, 32'h8000_0040);
        tick();
        check("rlw_ce_T2",   mem_ce,   1);
        tick();
        check("rlw_wbv_T3",  wb_valid, 1);
        check("rlw_wdata_T3", wb_wdata, 32'h0BAD_F00D);
        check("rlw_wreg_T3", wb_wreg,  9);
        tick();

        // Back-to-back loads with ex_valid held high throughout.
        drive(1'b1, OP_LW, 32'h8000_0100, 32'h0, 32'h0, 5'd10, 1'b1);
        mem_rdata = 32'h1111_1111;
        tick();
        check("bb1_ce_T1", mem_ce, 1);
        tick();
        check("bb1_ce_T2", mem_ce, 1);
        tick();
        drive(1'b1, OP_LW, 32'h8000_0200, 32'h0, 32'h0, 5'd11, 1'b1);
        mem_rdata = 32'h2222_2222;
        check("bb1_ce_done",    mem_ce,    0);
        check("bb1_stall_done", stall_req, 0);
        check("bb1_wbv",        wb_valid,  1);
        check("bb1_wdata",      wb_wdata,  32'h1111_1111);
        check("bb1_wreg",       wb_wreg,   10);
        tick();
        check("bb2_stall_T", stall_req, 1);
        check("bb2_ce_T",    mem_ce,    0);
        check("bb2_wbv_T",   wb_valid,  0);
        tick();
        drive(1'b0, 6'd0, '0, '0, '0, 5'd0, 1'b0);
        check("bb2_ce_T1",   mem_ce,   1);
        check("bb2_addr_T1", mem_addr, 32'h8000_0200);
        tick();
        check("bb2_ce_T2",   mem_ce,   1);
        tick();
        check("bb2_ce_T3",   mem_ce,   0);
        check("bb2_wbv_T3",  wb_valid, 1);
        check("bb2_wdata",   wb_wdata, 32'h2222_2222);
        check("bb2_wreg",    wb_wreg,  11);
        tick();
        check("bb2_wbv_T4",  wb_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
